// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Bridges the multicycle controller/datapath to a word-wide synchronous RAM
// that has no byte enables. It performs LW, LB, LBU and SB. Byte loads are
// sign- or zero-extended. Byte stores are done as read-modify-write, so the
// RAM only ever sees whole-word accesses. Byte order is big-endian: lane 0 is
// bits [31:24] and lane 3 is bits [7:0].
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous reset, active-low
//   req        request strobe, sampled only in IDLE
//   MemWrite   1 = store, 0 = load
//   MemMode    00 word, 01 signed byte (also SB), 10 unsigned byte, 11 reserved
//   addr       byte address
//   wdata      store data (byte stores use wdata[7:0])
//   rdata      load result, held until the next load completes
//   done       one-cycle completion pulse
//   busy       high whenever the FSM is not in IDLE
//   err        one-cycle pulse with done for a rejected request
//   ram_addr   RAM word address (addr[AW+1:2]; upper address bits ignored)
//   ram_we     RAM write enable, forced low while reset is asserted
//   ram_wdata  RAM write data
//   ram_rdata  RAM read data, valid one cycle after a read address

module mem_access_unit #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          MemWrite,
    input  logic [1:0]    MemMode,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          done,
    output logic          busy,
    output logic          err,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [1:0] MODE_WORD  = 2'b00;
    localparam logic [1:0] MODE_SBYTE = 2'b01;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    state_t        state_q, state_d;
    logic [AW+1:0] addr_q,  addr_d;   // only the bits that reach the RAM or pick a lane
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    mode_q,  mode_d;
    logic          we_q,    we_d;
    logic          err_q,   err_d;    // request was rejected; reported in RESP
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   merge_q, merge_d;

    logic [7:0]    sel_byte;
    logic [31:0]   merged_word;
    logic          ram_we_raw;

    // Lane select and merge for the captured address (big-endian lanes).
    always_comb begin
        sel_byte    = 8'h00;
        merged_word = ram_rdata;
        unique case (addr_q[1:0])
            2'd0: begin sel_byte = ram_rdata[31:24]; merged_word[31:24] = wdata_q[7:0]; end
            2'd1: begin sel_byte = ram_rdata[23:16]; merged_word[23:16] = wdata_q[7:0]; end
            2'd2: begin sel_byte = ram_rdata[15:8];  merged_word[15:8]  = wdata_q[7:0]; end
            2'd3: begin sel_byte = ram_rdata[7:0];   merged_word[7:0]   = wdata_q[7:0]; end
        endcase
    end

    // Next-state logic.
    // NOTE: every variable gets its hold value before the case, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mode_d  = mode_q;
        we_d    = we_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        merge_d = merge_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    mode_d  = MemMode;
                    we_d    = MemWrite;
                    // Reserved mode or a misaligned word access never touches the RAM.
                    if (MemMode == MODE_RSVD ||
                        (MemMode == MODE_WORD && addr[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q && mode_q == MODE_WORD) state_d = S_RESP;
                else                             state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (we_q) begin
                    merge_d = merged_word;
                    state_d = S_WRITE;
                end else begin
                    if (mode_q == MODE_WORD)       rdata_d = ram_rdata;
                    else if (mode_q == MODE_SBYTE) rdata_d = {{24{sel_byte[7]}}, sel_byte};
                    else                           rdata_d = {24'h0, sel_byte};
                    state_d = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only; the reset is
    // synchronous, so it is just the highest-priority branch under the clock.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mode_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mode_q  <= mode_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
        end
    end

    assign ram_we_raw = (state_q == S_ISSUE && we_q && mode_q == MODE_WORD) ||
                        (state_q == S_WRITE);

    // Gating with reset abandons an in-flight write in the very cycle reset is seen.
    assign ram_we    = ram_we_raw & reset;
    assign ram_wdata = (state_q == S_WRITE) ? merge_q : wdata_q;
    assign ram_addr  = addr_q[AW+1:2];

    assign rdata = rdata_q;
    assign done  = (state_q == S_RESP);
    assign err   = (state_q == S_RESP) && err_q;
    assign busy  = (state_q != S_IDLE);

endmodule
